// File: rtl/mips_multicycle_controller.sv
// Moore FSM control unit for a multicycle MIPS datapath with a shared ALU and unified memory.
// Memory-access states can stall on a memready handshake from slow memory.
module mips_multicycle_controller #(
    parameter bit HAS_MEMREADY = 1'b1,
    parameter bit HAS_BNE      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] RTYPEEX  = 4'd6;
    localparam logic [3:0] RTYPEWB  = 4'd7;
    localparam logic [3:0] BRANCHEX = 4'd8;
    localparam logic [3:0] ADDIEX   = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JEX      = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type function codes this controller supports.
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_aluctl(input logic [5:0] f);
        logic [2:0] ctl;
        case (f)
            6'b100000: ctl = ALU_ADD;
            6'b100010: ctl = ALU_SUB;
            6'b100100: ctl = ALU_AND;
            6'b100101: ctl = ALU_OR;
            6'b101010: ctl = ALU_SLT;
            default:   ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic       mem_ok_s;
    logic       is_bne_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       pcen_s;
    logic       regwrite_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    assign mem_ok_s = HAS_MEMREADY ? memready : 1'b1;
    assign is_bne_s = HAS_BNE && (op == OP_BNE);

    // State register; reset returns to FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode; memready and zero only gate strobes.
    always_comb begin
        next_state_s = FETCH;
        iord         = 1'b0;
        irwrite_s    = 1'b0;
        memwrite_s   = 1'b0;
        pcen_s       = 1'b0;
        pcsrc        = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        alucontrol   = ALU_ADD;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_s   = 1'b0;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        case (state_r)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = mem_ok_s;
                pcen_s    = mem_ok_s;
                if (mem_ok_s) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            next_state_s = RTYPEEX;
                        end else begin
                            illegal_op_s = 1'b1;
                            next_state_s = FETCH;
                        end
                    end
                    OP_BEQ:  next_state_s = BRANCHEX;
                    OP_BNE: begin
                        if (HAS_BNE) begin
                            next_state_s = BRANCHEX;
                        end else begin
                            illegal_op_s = 1'b1;
                            next_state_s = FETCH;
                        end
                    end
                    OP_ADDI: next_state_s = ADDIEX;
                    OP_J:    next_state_s = JEX;
                    default: begin
                        illegal_op_s = 1'b1;
                        next_state_s = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_SW) begin
                    next_state_s = MEMWR;
                end else begin
                    next_state_s = MEMRD;
                end
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ok_s) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMRD;
                end
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            MEMWR: begin
                // Write strobe held for the whole access; retirement waits on memready.
                iord         = 1'b1;
                memwrite_s   = 1'b1;
                instr_done_s = mem_ok_s;
                if (mem_ok_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            RTYPEEX: begin
                alusrca      = 1'b1;
                alucontrol   = funct_aluctl(funct);
                next_state_s = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            BRANCHEX: begin
                alusrca      = 1'b1;
                alucontrol   = ALU_SUB;
                pcsrc        = 2'b01;
                pcen_s       = is_bne_s ? ~zero : zero;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                next_state_s = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            JEX: begin
                pcsrc        = 2'b10;
                pcen_s       = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Reset kills every strobe in the same cycle, aborting any in-flight access.
    assign irwrite    = irwrite_s    & ~reset;
    assign memwrite   = memwrite_s   & ~reset;
    assign pcen       = pcen_s       & ~reset;
    assign regwrite   = regwrite_s   & ~reset;
    assign instr_done = instr_done_s & ~reset;
    assign illegal_op = illegal_op_s & ~reset;
    assign state      = state_r;

endmodule
